// File: rtl/bp_nonsynth_cosim_pkg.sv
// Shared types for the nonsynth commit/writeback scoreboard.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
//
// Commit entries are stored at fixed maximum widths so that one struct type
// serves any parameterisation up to these limits. Narrower fields are
// zero-extended on enqueue and truncated on retire.
package bp_nonsynth_cosim_pkg;

    typedef enum logic [2:0] {
        e_err_none       = 3'd0,
        e_err_commit_ovf = 3'd1,
        e_err_wb_ovf     = 3'd2,
        e_err_multi_wb   = 3'd3,
        e_err_timeout    = 3'd4
    } bp_cosim_err_e;

    localparam int cosim_pc_width_lp    = 64;
    localparam int cosim_instr_width_lp = 32;
    localparam int cosim_wb_ports_lp    = 4;

    typedef struct packed {
        logic [cosim_pc_width_lp-1:0]    pc;
        logic [cosim_instr_width_lp-1:0] instr;
        logic                            trap;
        logic                            debug;
        logic [cosim_wb_ports_lp-1:0]    wb;
    } bp_cosim_commit_s;

    // True when at most one bit of v is set.
    function automatic logic is_onehot0(logic [cosim_wb_ports_lp-1:0] v);
        return (v & (v - cosim_wb_ports_lp'(1))) == '0;
    endfunction

endpackage

// File: rtl/bp_nonsynth_wb_bank.sv
// Per-port writeback bank: one FIFO per architectural register.
// Latency: a push is visible at the head one cycle later (no bypass).
// Backpressure: pushes to a full register FIFO are dropped; caller flags it.
//
// Ports:
//   clk_i, reset_i  clock, async active-high reset
//   enq_v_i         push enq_data_i into FIFO enq_addr_i (ignored when full)
//   deq_i           one-hot register select; pops that FIFO's head
//   v_o / full_o    per-register nonempty / full
//   data_o          per-register head data, register r at [r*data_width_p +: data_width_p]
module bp_nonsynth_wb_bank #(
    parameter int data_width_p = 64,
    parameter int rf_els_p     = 32,
    parameter int wb_depth_p   = 8
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             enq_v_i,
    input  logic [$clog2(rf_els_p)-1:0]      enq_addr_i,
    input  logic [data_width_p-1:0]          enq_data_i,
    input  logic [rf_els_p-1:0]              deq_i,
    output logic [rf_els_p-1:0]              v_o,
    output logic [rf_els_p-1:0]              full_o,
    output logic [rf_els_p*data_width_p-1:0] data_o
);

    localparam int addr_w_lp = $clog2(rf_els_p);
    localparam int ptr_w_lp  = $clog2(wb_depth_p);
    localparam logic [ptr_w_lp:0] ptr_one_lp = 1;

    logic [data_width_p-1:0] mem_q  [rf_els_p][wb_depth_p];
    logic [ptr_w_lp:0]       wptr_q [rf_els_p];
    logic [ptr_w_lp:0]       rptr_q [rf_els_p];

    // Wrap-bit pointers: equal = empty, equal except MSB = full.
    always_comb begin
        v_o    = '0;
        full_o = '0;
        data_o = '0;
        for (int r = 0; r < rf_els_p; r++) begin
            v_o[r]    = (wptr_q[r] != rptr_q[r]);
            full_o[r] = (wptr_q[r][ptr_w_lp] != rptr_q[r][ptr_w_lp])
                     && (wptr_q[r][ptr_w_lp-1:0] == rptr_q[r][ptr_w_lp-1:0]);
            data_o[r*data_width_p +: data_width_p] = mem_q[r][rptr_q[r][ptr_w_lp-1:0]];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int r = 0; r < rf_els_p; r++) begin
                wptr_q[r] <= '0;
                rptr_q[r] <= '0;
                for (int d = 0; d < wb_depth_p; d++) begin
                    mem_q[r][d] <= '0;
                end
            end
        end else begin
            for (int r = 0; r < rf_els_p; r++) begin
                if (enq_v_i && !full_o[r] && (enq_addr_i == addr_w_lp'(r))) begin
                    mem_q[r][wptr_q[r][ptr_w_lp-1:0]] <= enq_data_i;
                    wptr_q[r] <= wptr_q[r] + ptr_one_lp;
                end
                if (deq_i[r]) begin
                    rptr_q[r] <= rptr_q[r] + ptr_one_lp;
                end
            end
        end
    end

endmodule

// File: rtl/bp_nonsynth_commit_scoreboard.sv
// Pairs in-order commits with late register-file writebacks and emits retire records.
// Latency: commit at cycle t can retire at t+1; a writeback at t releases its commit at t+1.
// Backpressure: valid/ready on the retire record; record held stable while ~retire_ready_i.
//
// Ports:
//   clk_i, reset_i            clock, async active-high reset
//   en_i                      gates commit and writeback enqueue
//   instr_cap_i               retire cap (0 = unlimited); done_o sticks once reached
//   commit_*_i                commit packet; commit_wb_i one-hot port expecting a writeback
//   wb_v_i/wb_addr_i/wb_data_i per-port writebacks, packed port-major
//   retire_*_o, retire_ready_i retire record handshake
//   retire_cnt_o              counted instret (no traps, no debug), saturating
//   done_o, error_o, error_code_o  sticky status; first error code wins
module bp_nonsynth_commit_scoreboard
    import bp_nonsynth_cosim_pkg::*;
#(
    parameter int vaddr_width_p  = 39,
    parameter int instr_width_p  = 32,
    parameter int data_width_p   = 64,
    parameter int rf_els_p       = 32,
    parameter int num_wb_ports_p = 2,
    parameter int commit_depth_p = 16,
    parameter int wb_depth_p     = 8,
    parameter int timeout_p      = 1024
) (
    input  logic                                         clk_i,
    input  logic                                         reset_i,
    input  logic                                         en_i,
    input  logic [31:0]                                  instr_cap_i,
    input  logic                                         commit_v_i,
    input  logic [vaddr_width_p-1:0]                     commit_pc_i,
    input  logic [instr_width_p-1:0]                     commit_instr_i,
    input  logic                                         commit_trap_i,
    input  logic                                         commit_debug_i,
    input  logic [num_wb_ports_p-1:0]                    commit_wb_i,
    input  logic [num_wb_ports_p-1:0]                    wb_v_i,
    input  logic [num_wb_ports_p*$clog2(rf_els_p)-1:0]   wb_addr_i,
    input  logic [num_wb_ports_p*data_width_p-1:0]       wb_data_i,
    output logic                                         retire_v_o,
    input  logic                                         retire_ready_i,
    output logic [vaddr_width_p-1:0]                     retire_pc_o,
    output logic [instr_width_p-1:0]                     retire_instr_o,
    output logic                                         retire_trap_o,
    output logic [num_wb_ports_p-1:0]                    retire_wb_o,
    output logic [data_width_p-1:0]                      retire_data_o,
    output logic [31:0]                                  retire_cnt_o,
    output logic                                         done_o,
    output logic                                         error_o,
    output logic [2:0]                                   error_code_o
);

    localparam int addr_w_lp   = $clog2(rf_els_p);
    localparam int cq_ptr_w_lp = $clog2(commit_depth_p);
    localparam int wd_w_lp     = $clog2(timeout_p + 1);

    // ---------------- commit queue ----------------
    bp_cosim_commit_s        cq_mem_q [commit_depth_p];
    logic [cq_ptr_w_lp:0]    cq_wptr_q, cq_wptr_d, cq_rptr_q, cq_rptr_d;
    logic                    cq_empty, cq_full, cq_push;
    logic                    wb_onehot0;
    logic [cosim_wb_ports_lp-1:0] commit_wb_ext;
    bp_cosim_commit_s        cq_new, cq_head;
    logic [num_wb_ports_p-1:0] head_wb;
    logic [addr_w_lp-1:0]    head_rd;

    assign cq_empty = (cq_wptr_q == cq_rptr_q);
    // Full comes straight from the pointer flops, so a pop in the same cycle
    // cannot make room for an incoming commit.
    assign cq_full  = (cq_wptr_q[cq_ptr_w_lp] != cq_rptr_q[cq_ptr_w_lp])
                   && (cq_wptr_q[cq_ptr_w_lp-1:0] == cq_rptr_q[cq_ptr_w_lp-1:0]);
    assign cq_push  = commit_v_i & en_i & ~cq_full;

    assign commit_wb_ext = cosim_wb_ports_lp'(commit_wb_i);
    assign wb_onehot0    = is_onehot0(commit_wb_ext);

    always_comb begin
        cq_new       = '0;
        cq_new.pc    = cosim_pc_width_lp'(commit_pc_i);
        cq_new.instr = cosim_instr_width_lp'(commit_instr_i);
        cq_new.trap  = commit_trap_i;
        cq_new.debug = commit_debug_i;
        // A malformed multi-port request is kept but treated as no writeback.
        cq_new.wb    = wb_onehot0 ? commit_wb_ext : '0;
    end

    assign cq_head = cq_mem_q[cq_rptr_q[cq_ptr_w_lp-1:0]];
    assign head_wb = num_wb_ports_p'(cq_head.wb);
    assign head_rd = cq_head.instr[7 +: addr_w_lp];

    // ---------------- writeback banks ----------------
    logic [rf_els_p-1:0]              bank_v    [num_wb_ports_p];
    logic [rf_els_p-1:0]              bank_full [num_wb_ports_p];
    logic [rf_els_p-1:0]              bank_deq  [num_wb_ports_p];
    logic [rf_els_p*data_width_p-1:0] bank_data [num_wb_ports_p];
    logic [num_wb_ports_p-1:0]        port_match, port_ovf;
    logic                             handshake;

    for (genvar p = 0; p < num_wb_ports_p; p++) begin : g_port
        logic [addr_w_lp-1:0] wr_addr;
        logic                 wr_v;

        assign wr_addr = wb_addr_i[p*addr_w_lp +: addr_w_lp];
        assign wr_v    = wb_v_i[p] & en_i;

        bp_nonsynth_wb_bank #(
            .data_width_p(data_width_p),
            .rf_els_p    (rf_els_p),
            .wb_depth_p  (wb_depth_p)
        ) u_bank (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .enq_v_i   (wr_v),
            .enq_addr_i(wr_addr),
            .enq_data_i(wb_data_i[p*data_width_p +: data_width_p]),
            .deq_i     (bank_deq[p]),
            .v_o       (bank_v[p]),
            .full_o    (bank_full[p]),
            .data_o    (bank_data[p])
        );

        assign port_ovf[p]   = wr_v & bank_full[p][wr_addr];
        assign port_match[p] = head_wb[p] & bank_v[p][head_rd];
        assign bank_deq[p]   = (handshake & head_wb[p]) ? (rf_els_p'(1) << head_rd) : '0;
    end

    // ---------------- retire ----------------
    logic retirable, stalled;
    logic done_q, done_d;

    assign retirable  = ~cq_empty & ((head_wb == '0) | (|port_match));
    assign stalled    = ~cq_empty & ~retirable;
    assign retire_v_o = retirable & ~done_q;
    assign handshake  = retire_v_o & retire_ready_i;

    assign retire_pc_o    = vaddr_width_p'(cq_head.pc);
    assign retire_instr_o = instr_width_p'(cq_head.instr);
    assign retire_trap_o  = cq_head.trap;
    assign retire_wb_o    = head_wb;

    always_comb begin
        retire_data_o = '0;
        for (int p = 0; p < num_wb_ports_p; p++) begin
            if (port_match[p]) begin
                retire_data_o = bank_data[p][head_rd*data_width_p +: data_width_p];
            end
        end
    end

    assign cq_wptr_d = cq_wptr_q + (cq_ptr_w_lp+1)'(cq_push);
    assign cq_rptr_d = cq_rptr_q + (cq_ptr_w_lp+1)'(handshake);

    // ---------------- counters, watchdog, errors ----------------
    logic [31:0]         cnt_q, cnt_d;
    logic [wd_w_lp-1:0]  wd_q, wd_d;
    logic                timeout_hit;
    logic                error_q, error_d;
    bp_cosim_err_e       code_q, code_d;

    always_comb begin
        cnt_d = cnt_q;
        if (handshake && !cq_head.trap && !cq_head.debug && (cnt_q != '1)) begin
            cnt_d = cnt_q + 32'd1;
        end
        // Uses the next count so retire_v_o drops right after the capping pop.
        done_d = done_q | ((instr_cap_i != '0) && (cnt_d == instr_cap_i));
    end

    // Watchdog only runs while the head waits on a writeback; a retirable head
    // (including one held by backpressure) keeps it at zero.
    always_comb begin
        wd_d = wd_q;
        if (handshake || retirable) begin
            wd_d = '0;
        end else if (stalled && (wd_q != wd_w_lp'(timeout_p))) begin
            wd_d = wd_q + wd_w_lp'(1);
        end
    end
    assign timeout_hit = stalled && (wd_q == wd_w_lp'(timeout_p - 1));

    // Lowest code wins among same-cycle sources; nothing overwrites a latched code.
    always_comb begin
        error_d = error_q;
        code_d  = code_q;
        if (!error_q) begin
            if (commit_v_i & en_i & cq_full) begin
                error_d = 1'b1;
                code_d  = e_err_commit_ovf;
            end else if (|port_ovf) begin
                error_d = 1'b1;
                code_d  = e_err_wb_ovf;
            end else if (cq_push & ~wb_onehot0) begin
                error_d = 1'b1;
                code_d  = e_err_multi_wb;
            end else if (timeout_hit) begin
                error_d = 1'b1;
                code_d  = e_err_timeout;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < commit_depth_p; i++) begin
                cq_mem_q[i] <= '0;
            end
            cq_wptr_q <= '0;
            cq_rptr_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            wd_q      <= '0;
            error_q   <= 1'b0;
            code_q    <= e_err_none;
        end else begin
            if (cq_push) begin
                cq_mem_q[cq_wptr_q[cq_ptr_w_lp-1:0]] <= cq_new;
            end
            cq_wptr_q <= cq_wptr_d;
            cq_rptr_q <= cq_rptr_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            wd_q      <= wd_d;
            error_q   <= error_d;
            code_q    <= code_d;
        end
    end

    assign retire_cnt_o = cnt_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign error_code_o = code_q;

endmodule

// File: tb/tb_bp_nonsynth_commit_scoreboard.sv
module tb_bp_nonsynth_commit_scoreboard;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b1;
    logic [31:0]  instr_cap = '0;
    logic         commit_v = 1'b0;
    logic [38:0]  commit_pc = '0;
    logic [31:0]  commit_instr = '0;
    logic         commit_trap = 1'b0;
    logic         commit_debug = 1'b0;
    logic [1:0]   commit_wb = '0;
    logic [1:0]   wb_v = '0;
    logic [9:0]   wb_addr = '0;
    logic [127:0] wb_data = '0;
    logic         retire_v;
    logic         retire_ready = 1'b0;
    logic [38:0]  retire_pc;
    logic [31:0]  retire_instr;
    logic         retire_trap;
    logic [1:0]   retire_wb;
    logic [63:0]  retire_data;
    logic [31:0]  retire_cnt;
    logic         done;
    logic         error;
    logic [2:0]   error_code;

    always #5 clk = ~clk;

    bp_nonsynth_commit_scoreboard dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .en_i          (en),
        .instr_cap_i   (instr_cap),
        .commit_v_i    (commit_v),
        .commit_pc_i   (commit_pc),
        .commit_instr_i(commit_instr),
        .commit_trap_i (commit_trap),
        .commit_debug_i(commit_debug),
        .commit_wb_i   (commit_wb),
        .wb_v_i        (wb_v),
        .wb_addr_i     (wb_addr),
        .wb_data_i     (wb_data),
        .retire_v_o    (retire_v),
        .retire_ready_i(retire_ready),
        .retire_pc_o   (retire_pc),
        .retire_instr_o(retire_instr),
        .retire_trap_o (retire_trap),
        .retire_wb_o   (retire_wb),
        .retire_data_o (retire_data),
        .retire_cnt_o  (retire_cnt),
        .done_o        (done),
        .error_o       (error),
        .error_code_o  (error_code)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one commit for one cycle starting at a negedge; returns at the next negedge.
    task automatic commit(input logic [38:0] pc, input logic [31:0] instr,
                          input logic trap, input logic dbg, input logic [1:0] wb);
        commit_v = 1'b1; commit_pc = pc; commit_instr = instr;
        commit_trap = trap; commit_debug = dbg; commit_wb = wb;
        @(negedge clk);
        commit_v = 1'b0; commit_trap = 1'b0; commit_debug = 1'b0; commit_wb = '0;
    endtask

    task automatic wb_write(input int port, input logic [4:0] a, input logic [63:0] d);
        wb_v[port] = 1'b1;
        wb_addr[port*5 +: 5] = a;
        wb_data[port*64 +: 64] = d;
        @(negedge clk);
        wb_v = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        commit_v = 1'b0; wb_v = '0; retire_ready = 1'b0; instr_cap = '0; en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [38:0] pc;
        logic [31:0] instr;
        logic        trap;
        logic        dbg;
        logic [1:0]  cwb;
        logic [4:0]  waddr;
        logic [63:0] wdata;
        logic [63:0] exp_data;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] got[$];
        logic [38:0] s_pc;
        logic [63:0] s_data;
        logic [31:0] s_instr;
        logic [1:0]  s_wb;
        logic        stable;
        int          pops;

        //            pc          instr         trap dbg cwb    addr  wdata                  exp_data               cnt
        vecs[0] = '{39'h1000, 32'h0010_0293, 1'b0, 1'b0, 2'b01, 5'd5,  64'h1234,              64'h1234,              32'd1};
        vecs[1] = '{39'h1004, 32'h0011_2023, 1'b0, 1'b0, 2'b00, 5'd0,  64'h0,                 64'h0,                 32'd2};
        vecs[2] = '{39'h1008, 32'h0000_01D3, 1'b0, 1'b0, 2'b10, 5'd3,  64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 32'd3};
        vecs[3] = '{39'h100C, 32'h0000_0013, 1'b0, 1'b0, 2'b01, 5'd0,  64'h55,                64'h55,                32'd4};
        vecs[4] = '{39'h1010, 32'h0000_0073, 1'b1, 1'b0, 2'b00, 5'd0,  64'h0,                 64'h0,                 32'd4};
        vecs[5] = '{39'h1014, 32'h0010_0293, 1'b0, 1'b1, 2'b01, 5'd5,  64'h77,                64'h77,                32'd4};
        vecs[6] = '{39'h7F_FFFF_FFFC, 32'h0000_0F93, 1'b0, 1'b0, 2'b01, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'd5};

        // Reset state
        @(negedge clk);
        chk("rst_retire_v", retire_v, 0);
        chk("rst_cnt", retire_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_code", error_code, 0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven commit/writeback pairing
        for (int i = 0; i < 7; i++) begin
            commit(vecs[i].pc, vecs[i].instr, vecs[i].trap, vecs[i].dbg, vecs[i].cwb);
            if (vecs[i].cwb != 2'b00) begin
                chk($sformatf("v%0d_wait_wb", i), retire_v, 0);
                repeat (2) @(negedge clk);
                wb_write(vecs[i].cwb[1] ? 1 : 0, vecs[i].waddr, vecs[i].wdata);
            end
            chk($sformatf("v%0d_valid", i), retire_v, 1);
            chk($sformatf("v%0d_pc", i), retire_pc, vecs[i].pc);
            chk($sformatf("v%0d_instr", i), retire_instr, vecs[i].instr);
            chk($sformatf("v%0d_data", i), retire_data, vecs[i].exp_data);
            chk($sformatf("v%0d_wb", i), retire_wb, vecs[i].cwb);
            chk($sformatf("v%0d_trap", i), retire_trap, vecs[i].trap);
            retire_ready = 1'b1;
            @(negedge clk);
            retire_ready = 1'b0;
            chk($sformatf("v%0d_popped", i), retire_v, 0);
            chk($sformatf("v%0d_cnt", i), retire_cnt, vecs[i].exp_cnt);
        end

        // Three early writebacks to x7 drain in order
        for (int i = 1; i <= 3; i++) wb_write(0, 5'd7, 64'(i));
        retire_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c < 3) begin
                commit_v = 1'b1; commit_pc = 39'h2000 + 39'(4*c);
                commit_instr = 32'h0000_0393; commit_wb = 2'b01;
            end else begin
                commit_v = 1'b0; commit_wb = '0;
            end
            @(negedge clk);
            if (retire_v) got.push_back(retire_data);
        end
        chk("x7_count", 64'(got.size()), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk($sformatf("x7_order%0d", i), got[i], 64'(i + 1));
        chk("x7_cnt", retire_cnt, 8);
        commit(39'h2100, 32'h0000_0393, 1'b0, 1'b0, 2'b01);
        repeat (2) @(negedge clk);
        chk("x7_fifo_empty", retire_v, 0);
        wb_write(0, 5'd7, 64'h4);
        chk("x7_late_data", retire_data, 64'h4);
        @(negedge clk);
        retire_ready = 1'b0;
        chk("x7_cnt2", retire_cnt, 9);

        // Backpressure: record held stable for 20 cycles
        wb_write(0, 5'd9, 64'hABCD);
        commit(39'h3000, 32'h0000_0493, 1'b0, 1'b0, 2'b01);
        chk("bp_valid", retire_v, 1);
        s_pc = retire_pc; s_data = retire_data; s_instr = retire_instr; s_wb = retire_wb;
        chk("bp_first_data", retire_data, 64'hABCD);
        stable = 1'b1;
        wb_write(0, 5'd9, 64'h9999);
        for (int c = 0; c < 19; c++) begin
            if (!retire_v || retire_pc !== s_pc || retire_data !== s_data ||
                retire_instr !== s_instr || retire_wb !== s_wb) stable = 1'b0;
            @(negedge clk);
        end
        chk("bp_stable", stable, 1);
        chk("bp_no_error", error, 0);
        retire_ready = 1'b1;
        @(negedge clk);
        retire_ready = 1'b0;
        chk("bp_single_pop", retire_v, 0);
        chk("bp_cnt", retire_cnt, 10);

        // en_i low blocks enqueue
        en = 1'b0;
        commit(39'h3100, 32'h0000_0013, 1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("en_gate", retire_v, 0);
        en = 1'b1;

        // Instruction cap: trap/debug do not count
        do_reset();
        instr_cap = 32'd3;
        commit(39'h4000, 32'h0000_0073, 1'b1, 1'b0, 2'b00);
        commit(39'h4004, 32'h0000_0013, 1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 5; i++) commit(39'h4008 + 39'(4*i), 32'h0000_0013, 1'b0, 1'b0, 2'b00);
        chk("cap_done_before", done, 0);
        retire_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 20; c++) begin
            if (retire_v) pops++;
            @(negedge clk);
        end
        chk("cap_pops", 64'(pops), 5);
        chk("cap_done", done, 1);
        chk("cap_cnt", retire_cnt, 3);
        chk("cap_valid_low", retire_v, 0);
        instr_cap = '0;
        @(negedge clk);
        chk("cap_done_sticky", done, 1);

        // Writeback overflow ties with a multi-port commit: lower code wins
        do_reset();
        for (int i = 0; i < 8; i++) wb_write(0, 5'd9, 64'(i));
        chk("wbovf_none_yet", error, 0);
        commit_v = 1'b1; commit_pc = 39'h5000; commit_instr = 32'h0000_0013; commit_wb = 2'b11;
        wb_write(0, 5'd9, 64'hFF);
        commit_v = 1'b0; commit_wb = '0;
        chk("wbovf_err", error, 1);
        chk("wbovf_code", error_code, 2);

        // Multi-port request alone: queued as no-writeback
        do_reset();
        commit(39'h5100, 32'h0000_0293, 1'b0, 1'b0, 2'b11);
        chk("multi_code", error_code, 3);
        chk("multi_valid", retire_v, 1);
        chk("multi_wb", retire_wb, 0);
        chk("multi_data", retire_data, 0);

        // Commit queue overrun, then timeout does not overwrite the code
        do_reset();
        for (int i = 0; i < 16; i++) commit(39'h6000 + 39'(4*i), 32'h0000_0013, 1'b0, 1'b0, 2'b00);
        chk("cq_full_no_err", error, 0);
        commit(39'h6100, 32'h0000_0013, 1'b0, 1'b0, 2'b00);
        chk("cq_ovf_err", error, 1);
        chk("cq_ovf_code", error_code, 1);
        retire_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("cq_drained", retire_v, 0);
        chk("cq_drop_cnt", retire_cnt, 16);
        commit(39'h6200, 32'h0000_01D3, 1'b0, 1'b0, 2'b10);
        repeat (1100) @(negedge clk);
        chk("cq_code_kept", error_code, 1);
        chk("cq_fp_waiting", retire_v, 0);
        wb_write(1, 5'd3, 64'hF00D);
        @(negedge clk);
        chk("cq_fp_cnt", retire_cnt, 17);

        // Reset mid-stream with 4 queued entries
        retire_ready = 1'b0;
        for (int i = 0; i < 4; i++) commit(39'h7000 + 39'(4*i), 32'h0000_0013, 1'b0, 1'b0, 2'b00);
        chk("mid_valid_pre", retire_v, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", retire_v, 0);
        chk("mid_rst_cnt", retire_cnt, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_code", error_code, 0);
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        commit(39'h7100, 32'h0000_0013, 1'b0, 1'b0, 2'b00);
        chk("mid_post_valid", retire_v, 1);
        chk("mid_post_pc", retire_pc, 39'h7100);
        retire_ready = 1'b1;
        @(negedge clk);
        retire_ready = 1'b0;
        chk("mid_post_cnt", retire_cnt, 1);
        chk("mid_post_empty", retire_v, 0);

        // Watchdog timeout on a missing fp writeback
        do_reset();
        commit(39'h8000, 32'h0000_01D3, 1'b0, 1'b0, 2'b10);
        repeat (1000) @(negedge clk);
        chk("wd_before", error, 0);
        repeat (40) @(negedge clk);
        chk("wd_err", error, 1);
        chk("wd_code", error_code, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
